spm_display_ctrl: RTL and testbench

- Owns the 4-digit multiplexed 7-segment display for the signed 8×8 SPM product.
- Latches a signed 16-bit product, drives its 15-bit magnitude into the combinational `to_bcd` converter, and captures the 19-bit BCD result into a 6-symbol buffer (sign + 5 digits).
- Time-multiplexes a scrollable 4-symbol window onto the anodes, with leading-zero blanking.
- Sits between the SPM result register and the board display pins.

---
 rtl/spm_display_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spm_display_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spm_display_ctrl.sv
// spm_display_ctrl: latches a signed SPM product, hands its magnitude to an
// external binary-to-BCD converter, captures the BCD result and scans a
// scrollable 4-symbol window (sign + 5 digits) onto a multiplexed 7-seg display.
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   prod_valid, prod[15:0]        signed product strobe and value
//   scroll_left, scroll_right     single-cycle window scroll pulses
//   bin_out[14:0]                 registered magnitude to the converter
//   bcd_in[18:0]                  BCD digits from the converter (D4..D0)
//   busy                          high while a product is being captured
//   an[3:0], seg[6:0]             active-low anodes and segments {g..a}
module spm_display_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prod_valid,
    input  logic [15:0] prod,
    input  logic        scroll_left,
    input  logic        scroll_right,
    output logic [14:0] bin_out,
    input  logic [18:0] bcd_in,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        SHOW,
        CAPTURE,
        LOAD
    } state_t;

    state_t          state;
    logic            sign_reg;
    logic            neg_disp;
    logic [4:0][3:0] dig;
    logic [1:0]      offset;
    logic [1:0]      scan;
    logic [CW-1:0]   cnt;

    logic [14:0]     mag;
    logic            nxt_neg;
    logic [4:0][3:0] nxt_dig;
    logic [1:0]      nxt_off;
    logic [4:0]      hide;
    logic [2:0]      sym;
    logic [2:0]      didx;
    logic [3:0]      nib;
    logic [6:0]      nxt_seg;
    logic            lz;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = SEG_BLANK;
        endcase
    endfunction

    // Low 15 bits of the two's-complement negation; -32768 wraps to 0 here
    // and is clamped to 32767.
    always_comb begin
        mag = prod[14:0];
        if (prod[15]) begin
            if (prod[14:0] == 15'd0) mag = 15'h7FFF;
            else                     mag = ~prod[14:0] + 15'd1;
        end
    end

    // Next buffer/offset, so the lit slot reflects a load or scroll on the
    // same edge that makes it.
    always_comb begin
        nxt_dig = dig;
        nxt_neg = neg_disp;
        nxt_off = offset;
        if (state == CAPTURE) begin
            nxt_dig = {1'b0, bcd_in};
            nxt_neg = sign_reg && (bin_out != 15'd0);
            nxt_off = 2'd2;
        end else if (state == SHOW && (scroll_left != scroll_right)) begin
            if (scroll_left && offset != 2'd0)  nxt_off = offset - 2'd1;
            if (scroll_right && offset != 2'd2) nxt_off = offset + 2'd1;
        end
    end

    // Leading-zero blanking: Dk hidden when Dk..D4 are all zero (k > 0).
    always_comb begin
        lz = 1'b1;
        hide = 5'b0;
        for (int k = 4; k >= 1; k--) begin
            lz = lz && (nxt_dig[k] == 4'd0);
            hide[k] = lz;
        end
    end

    // an[scan] shows symbol[offset + 3 - scan]; symbol 0 is the sign.
    always_comb begin
        sym = {1'b0, nxt_off} + {1'b0, ~scan};
        didx = 3'd5 - sym;
        nib = 4'd0;
        nxt_seg = SEG_BLANK;
        if (sym == 3'd0) begin
            nxt_seg = nxt_neg ? SEG_MINUS : SEG_BLANK;
        end else if (didx <= 3'd4) begin
            nib = nxt_dig[didx];
            nxt_seg = hide[didx] ? SEG_BLANK : enc(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SHOW;
            busy     <= 1'b0;
            bin_out  <= '0;
            sign_reg <= 1'b0;
            neg_disp <= 1'b0;
            dig      <= '0;
            offset   <= 2'd2;
            scan     <= 2'd0;
            cnt      <= '0;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
        end else begin
            dig      <= nxt_dig;
            neg_disp <= nxt_neg;
            offset   <= nxt_off;
            an       <= ~(4'b0001 << scan);
            seg      <= nxt_seg;
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                scan <= scan + 2'd1;
            end else begin
                cnt  <= cnt + CW'(1);
            end
            case (state)
                SHOW: begin
                    if (prod_valid) begin
                        state    <= CAPTURE;
                        busy     <= 1'b1;
                        sign_reg <= prod[15];
                        bin_out  <= mag;
                    end
                end
                CAPTURE: state <= LOAD;
                LOAD: begin
                    state <= SHOW;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= SHOW;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_display_ctrl.sv
// Directed self-checking bench for spm_display_ctrl (REFRESH_DIV = 4) with
// a behavioural binary-to-BCD model feeding bcd_in.
module tb_spm_display_ctrl;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MN = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        prod_valid;
    logic [15:0] prod;
    logic        scroll_left;
    logic        scroll_right;
    logic [14:0] bin_out;
    logic [18:0] bcd_in;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [18:0] bcd_model(input logic [14:0] b);
        int v;
        v = int'(b);
        return {3'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    assign bcd_in = bcd_model(bin_out);

    spm_display_ctrl #(.REFRESH_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .prod_valid(prod_valid),
        .prod(prod),
        .scroll_left(scroll_left),
        .scroll_right(scroll_right),
        .bin_out(bin_out),
        .bcd_in(bcd_in),
        .busy(busy),
        .an(an),
        .seg(seg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for each anode position from an[3] down to an[0] and
    // checks the segments shown there.
    task automatic chk_win(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] e [4];
        e[3] = e3;
        e[2] = e2;
        e[1] = e1;
        e[0] = e0;
        for (int p = 3; p >= 0; p--) begin
            int n;
            logic [3:0] want;
            n = 0;
            want = ~(4'b0001 << p);
            @(negedge clk);
            while (an !== want && n < 64) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_an%0d", tag, p), 32'(an), 32'(want));
            chk($sformatf("%s_seg%0d", tag, p), 32'(seg), 32'(e[p]));
        end
    endtask

    task automatic load_prod(input string tag, input logic [15:0] v, input logic [14:0] emag);
        prod = v;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        chk({tag, "_bin"}, 32'(bin_out), 32'(emag));
        chk({tag, "_busy1"}, 32'(busy), 1);
        @(posedge clk);
        #1;
        chk({tag, "_busy2"}, 32'(busy), 1);
        @(posedge clk);
        #1;
        chk({tag, "_busy3"}, 32'(busy), 0);
    endtask

    task automatic scroll(input logic l, input logic r);
        scroll_left = l;
        scroll_right = r;
        @(posedge clk);
        #1;
        scroll_left = 1'b0;
        scroll_right = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        prod_valid = 1'b0;
        prod = '0;
        scroll_left = 1'b0;
        scroll_right = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(BL));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bin", 32'(bin_out), 0);
        rst = 1'b0;

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("scan0_an", 32'(an), 32'hE);
        chk("scan0_seg", 32'(seg), 32'(S0));
        repeat (4) @(posedge clk);
        #1;
        chk("scan1_an", 32'(an), 32'hD);
        chk("scan1_seg", 32'(seg), 32'(BL));
        repeat (4) @(posedge clk);
        #1;
        chk("scan2_an", 32'(an), 32'hB);
        chk("scan2_seg", 32'(seg), 32'(BL));
        repeat (4) @(posedge clk);
        #1;
        chk("scan3_an", 32'(an), 32'h7);
        chk("scan3_seg", 32'(seg), 32'(BL));
        repeat (4) @(posedge clk);
        #1;
        chk("scan4_an", 32'(an), 32'hE);
        chk("scan4_seg", 32'(seg), 32'(S0));

        load_prod("n1234", 16'hFB2E, 15'd1234);
        chk_win("n1234_o2", S1, S2, S3, S4);
        scroll(1'b1, 1'b0);
        chk_win("n1234_o1", BL, S1, S2, S3);
        scroll(1'b1, 1'b0);
        chk_win("n1234_o0", MN, BL, S1, S2);
        scroll(1'b0, 1'b1);
        chk_win("n1234_r1", BL, S1, S2, S3);
        scroll(1'b0, 1'b1);
        chk_win("n1234_r2", S1, S2, S3, S4);

        load_prod("p16384", 16'h4000, 15'd16384);
        chk_win("p16384_o2", S6, S3, S8, S4);
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        chk_win("p16384_o0", BL, S1, S6, S3);
        scroll(1'b1, 1'b0);
        chk_win("p16384_sat0", BL, S1, S6, S3);
        scroll(1'b0, 1'b1);
        scroll(1'b0, 1'b1);
        scroll(1'b0, 1'b1);
        chk_win("p16384_sat2", S6, S3, S8, S4);

        load_prod("n32768", 16'h8000, 15'h7FFF);
        scroll(1'b1, 1'b0);
        scroll(1'b1, 1'b0);
        chk_win("n32768_o0", MN, S3, S2, S7);

        prod = 16'd77;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod = 16'd5;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ign_busy", 32'(busy), 0);
        chk("ign_bin", 32'(bin_out), 77);
        chk_win("ign_77", BL, BL, S7, S7);
        scroll(1'b1, 1'b1);
        chk_win("both_scroll", BL, BL, S7, S7);

        prod = 16'hFF9D;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_bin", 32'(bin_out), 0);
        chk_win("midrst_win", BL, BL, BL, S0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
